osc_monitor: RTL
================

# osc_monitor

Downstream monitor for the single-bit oscillating output of the case-1/case-2 FSM. It samples that output each clock and counts its transitions. It measures the rising-edge-to-rising-edge period in cycles and flags a stall when the signal stops toggling. Status outputs feed debug registers and a health flag for the system controller.

## Interface
Parameters:
- CNT_W, 8, width of `edge_cnt` and `period`.
- STALL_LIMIT, 16, consecutive no-edge cycles that constitute a stall. Legal range is 2..2^CNT_W-1.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- y_in  input  1  oscillating signal from the upstream FSM, synchronous to clk
- clr  input  1  synchronous soft clear, same effect as rst
- edge_cnt  output  CNT_W  total edges seen (rising plus falling), saturating
- period  output  CNT_W  last measured rising-to-rising period, in cycles
- period_valid  output  1  `period` holds a measurement from the current run
- stall  output  1  no edge for STALL_LIMIT cycles while active
- state  output  2  FSM state: 0=IDLE, 1=FIRST, 2=LOCKED, 3=STALLED

## Operation
- Edge detection:
  - `y_d` is a registered copy of `y_in`.
  - `edge = y_in ^ y_d`.
  - `rise = y_in & ~y_d`; `fall = ~y_in & y_d`.
- During rst or clr, `y_d` loads `y_in`, so no spurious edge is seen on the first cycle after release.
- rst or clr, including both together:
  - state=IDLE; edge_cnt=0, period=0, period_valid=0, stall=0.
  - Internal counters `run_cnt` and `per_cnt` = 0.
  - An edge in the same cycle is ignored.
- `edge_cnt` increments on every edge cycle and saturates at 2^CNT_W-1.
- `run_cnt`:
  - Cleared to 0 on an edge cycle.
  - Otherwise increments, saturating at STALL_LIMIT.
  - Counts in every state.
- `per_cnt`:
  - Set to 1 on a rise.
  - Otherwise increments, saturating at all-ones, in FIRST and LOCKED.
  - Held at 0 in IDLE and STALLED.
- FSM:
  - IDLE: rise -> FIRST. A fall counts but stays in IDLE. IDLE never stalls.
  - FIRST: rise -> LOCKED, with `period <= per_cnt`, `period_valid <= 1`. Stall condition -> STALLED.
  - LOCKED: each rise loads `period <= per_cnt`; stays in LOCKED. Stall condition -> STALLED.
  - STALLED: rise -> FIRST. Fall -> IDLE. Either edge clears stall.
- Stall condition is `!edge && run_cnt == STALL_LIMIT-1`, evaluated in FIRST or LOCKED.
- Entering STALLED sets stall=1 and period_valid=0. `period` keeps its last value.
- A rise in LOCKED on the same cycle the stall condition would fire is impossible, because an edge clears the condition; the edge wins.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Edge-to-count latency: an edge present on `y_in` in cycle t is reflected in `edge_cnt` at cycle t+1.
- Period definition: rises at cycles t and t+P give `period = P` and `period_valid = 1` from cycle t+P+1.
- Stall latency: with the last edge in cycle t, `stall` rises at cycle t+STALL_LIMIT+1, i.e. after STALL_LIMIT edge-free cycles t+1..t+STALL_LIMIT.
  - If an edge occurs at cycle t+STALL_LIMIT, stall never asserts.
- Stall exit: an edge in STALLED at cycle t gives stall=0 at cycle t+1.
- Reset or clear mid-run: takes effect at the next clock edge regardless of state. A run that is in progress is discarded.

## Test plan
- Reset, with CNT_W=8 and STALL_LIMIT=16:
  - Drive y_in=1 with rst high for 2 cycles, then release and hold y_in=1.
  - Required: every output is 0, state=0, and edge_cnt stays 0.
- Square wave:
  - From y_in=0, toggle every 2 cycles for 20 toggles (10 rises).
  - Required: edge_cnt=20, period=4, state=2.
  - Required: period_valid rises 1 cycle after the second rise.
  - Required: period is never a value other than 4.
- Stall boundary:
  - After the last edge, hold y_in for 15 cycles and then toggle. Required: stall stays 0.
  - Repeat holding for 16 cycles. Required: stall=1 on the 17th cycle, period_valid=0, period still 4, state=3.
- Recovery:
  - In STALLED, drive a rise. Required: stall=0 next cycle and state=1.
  - Then drive the next rise 6 cycles later. Required: period=6, period_valid=1, state=2.
  - Separately, a fall in STALLED gives state=0.
- Saturation:
  - Drive 300 toggles at period 2. Required: edge_cnt=255 and held there.
- Clear collisions:
  - Assert clr in the same cycle as a y_in edge during LOCKED. Required: next cycle all outputs are 0, state=0, and the edge is not counted.
  - Assert rst and clr together. Required: identical result.

Source files
------------

// File: rtl/osc_monitor.sv
// osc_monitor
//   Watches the single-bit oscillating output of the upstream FSM. It counts
//   every transition, measures the rising-to-rising period in clock cycles and
//   flags a stall when the signal stops toggling for STALL_LIMIT cycles.
//
// Ports
//   clk          in   system clock, all logic on the rising edge
//   rst          in   synchronous active-high reset
//   y_in         in   oscillating input, synchronous to clk
//   clr          in   synchronous soft clear, same effect as rst
//   edge_cnt     out  total edges seen (rise + fall), saturating
//   period       out  last measured rising-to-rising period, in cycles
//   period_valid out  period holds a measurement from the current run
//   stall        out  no edge for STALL_LIMIT cycles while active
//   state        out  0=IDLE, 1=FIRST, 2=LOCKED, 3=STALLED
module osc_monitor #(
    parameter int CNT_W       = 8,
    parameter int STALL_LIMIT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             y_in,
    input  logic             clr,
    output logic [CNT_W-1:0] edge_cnt,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             stall,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FIRST   = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_STALLED = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] STALL_LIM  = CNT_W'(STALL_LIMIT);
    localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(STALL_LIMIT - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
        return (v >= lim) ? lim : v + CNT_W'(1);
    endfunction

    state_t           state_q, state_d;
    logic             y_d_q, y_d_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             period_valid_q, period_valid_d;
    logic             stall_q, stall_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;

    logic edge_w, rise_w, fall_w, stall_hit;

    always_comb begin
        edge_w    = y_in ^ y_d_q;
        rise_w    = y_in & ~y_d_q;
        fall_w    = ~y_in & y_d_q;
        // run_cnt_q still reads SL-1 in the SL-th quiet cycle, so the stall
        // registers one cycle later, after exactly STALL_LIMIT quiet cycles.
        stall_hit = !edge_w && (run_cnt_q == STALL_LAST);

        state_d        = state_q;
        y_d_d          = y_in;
        edge_cnt_d     = edge_cnt_q;
        period_d       = period_q;
        period_valid_d = period_valid_q;
        stall_d        = stall_q;
        run_cnt_d      = edge_w ? '0 : sat_inc(run_cnt_q, STALL_LIM);
        per_cnt_d      = '0;

        if (edge_w) begin
            edge_cnt_d = sat_inc(edge_cnt_q, CNT_MAX);
        end

        // A rise starts a new measurement: the rise cycle itself counts as 1.
        if (rise_w) begin
            per_cnt_d = CNT_W'(1);
        end else if (state_q == ST_FIRST || state_q == ST_LOCKED) begin
            per_cnt_d = sat_inc(per_cnt_q, CNT_MAX);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (rise_w) state_d = ST_FIRST;
            end
            ST_FIRST, ST_LOCKED: begin
                if (rise_w) begin
                    state_d        = ST_LOCKED;
                    period_d       = per_cnt_q;
                    period_valid_d = 1'b1;
                end else if (stall_hit) begin
                    state_d        = ST_STALLED;
                    stall_d        = 1'b1;
                    period_valid_d = 1'b0;
                end
            end
            ST_STALLED: begin
                if (rise_w) begin
                    state_d = ST_FIRST;
                    stall_d = 1'b0;
                end else if (fall_w) begin
                    state_d = ST_IDLE;
                    stall_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Clear and reset also load y_d from y_in so the first cycle after
    // release never sees a spurious edge.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_q        <= ST_IDLE;
            y_d_q          <= y_in;
            edge_cnt_q     <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            stall_q        <= 1'b0;
            run_cnt_q      <= '0;
            per_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            y_d_q          <= y_d_d;
            edge_cnt_q     <= edge_cnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            stall_q        <= stall_d;
            run_cnt_q      <= run_cnt_d;
            per_cnt_q      <= per_cnt_d;
        end
    end

    assign edge_cnt     = edge_cnt_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign stall        = stall_q;
    assign state        = state_q;

endmodule
